// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: operand entry, ALU start/done handshake and display selection.
// Keys act only on the rising edge of key_valid; all outputs are registered.
module calc_sequencer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                alu_start,
  output logic [1:0]          alu_op,
  output logic [4*DIGITS-1:0] alu_a,
  output logic [4*DIGITS-1:0] alu_b,
  input  logic                alu_done,
  input  logic [4*DIGITS-1:0] alu_result,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] disp_value,
  output logic                disp_err,
  output logic [2:0]          digit_count,
  output logic [2:0]          state_dbg
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(DIGITS);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    START    = 3'd2,
    WAIT_ALU = 3'd3,
    SHOW     = 3'd4,
    ERROR    = 3'd5,
    ABORT    = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [1:0]     op_q, op_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           kprev_q, start_q, start_d, derr_q, derr_d;
  logic           key_ev, is_digit, is_op, is_clr, is_eq, clr_now;
  logic [1:0]     key_op;

  assign key_ev   = key_valid & ~kprev_q;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == 4'hA) || (key_code == 4'hB) || (key_code == 4'hC);
  assign is_clr   = (key_code == 4'hD);
  assign is_eq    = (key_code == 4'hE);
  assign key_op   = 2'(key_code - 4'hA);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    clr_now = 1'b0;
    case (state_q)
      ENTER_A, ENTER_B: begin
        if (key_ev) begin
          if (is_clr) begin
            clr_now = 1'b1;
          end else if (is_digit) begin
            if (cnt_q < MAX_CNT) begin
              if (state_q == ENTER_A) a_d = {a_q[W-5:0], key_code};
              else                    b_d = {b_q[W-5:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (is_op) begin
            if (state_q == ENTER_A) begin
              op_d    = key_op;
              cnt_d   = '0;
              state_d = ENTER_B;
            end else if (cnt_q == '0) begin
              op_d = key_op;
            end
          end else if (is_eq && state_q == ENTER_B) begin
            state_d = START;
          end
        end
      end
      // The request is already on the wire in START, so a clear here must drain it via ABORT.
      START:    state_d = (key_ev && is_clr) ? ABORT : WAIT_ALU;
      WAIT_ALU: begin
        if (alu_done) begin
          if (key_ev && is_clr) begin
            clr_now = 1'b1;
          end else if (alu_err) begin
            state_d = ERROR;
          end else begin
            res_d   = alu_result;
            state_d = SHOW;
          end
        end else if (key_ev && is_clr) begin
          state_d = ABORT;
        end
      end
      SHOW: begin
        if (key_ev) begin
          if (is_clr) begin
            clr_now = 1'b1;
          end else if (is_digit) begin
            a_d     = {{(W-4){1'b0}}, key_code};
            b_d     = '0;
            cnt_d   = 3'd1;
            state_d = ENTER_A;
          end else if (is_op) begin
            a_d     = res_q;
            b_d     = '0;
            op_d    = key_op;
            cnt_d   = '0;
            state_d = ENTER_B;
          end
        end
      end
      ERROR:   if (key_ev && is_clr) clr_now = 1'b1;
      ABORT:   if (alu_done) clr_now = 1'b1;
      default: state_d = ENTER_A;
    endcase

    if (clr_now) begin
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cnt_d   = '0;
      state_d = ENTER_A;
    end

    start_d = (state_d == START);
    derr_d  = (state_d == ERROR);
    case (state_d)
      ENTER_A:                 disp_d = a_d;
      ENTER_B:                 disp_d = (cnt_d != '0) ? b_d : a_d;
      START, WAIT_ALU, ABORT:  disp_d = b_d;
      SHOW:                    disp_d = res_d;
      default:                 disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      kprev_q <= 1'b0;
      start_q <= 1'b0;
      derr_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      kprev_q <= key_valid;
      start_q <= start_d;
      derr_q  <= derr_d;
      disp_q  <= disp_d;
    end
  end

  assign alu_start   = start_q;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign disp_value  = disp_q;
  assign disp_err    = derr_q;
  assign digit_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: drives key presses and a hand-operated ALU handshake.
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0;
  logic        alu_err = 1'b0;
  logic [15:0] disp_value;
  logic        disp_err;
  logic [2:0]  digit_count;
  logic [2:0]  state_dbg;

  int pass_cnt = 0;
  int total = 0;
  int start_cnt = 0;
  logic [15:0] cap_a, cap_b;
  logic [1:0]  cap_op;

  calc_sequencer #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_value(disp_value), .disp_err(disp_err), .digit_count(digit_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Capture each request on the falling edge, well away from register updates.
  always @(negedge clk) begin
    if (alu_start) begin
      start_cnt <= start_cnt + 1;
      cap_a  <= alu_a;
      cap_b  <= alu_b;
      cap_op <= alu_op;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press(input logic [3:0] c);
    @(posedge clk); #1;
    key_code  = c;
    key_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic alu_reply(input logic [15:0] r, input logic e);
    @(posedge clk); #1;
    alu_done = 1'b1; alu_result = r; alu_err = e;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_result = 16'h0; alu_err = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (state_dbg !== 3'd0) $display("FAIL rst_state got %0d exp 0", state_dbg); else pass_cnt++;
    total++; if (disp_value !== 16'h0) $display("FAIL rst_disp got %h exp 0000", disp_value); else pass_cnt++;
    total++; if (digit_count !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", digit_count); else pass_cnt++;
    total++; if ({alu_start, alu_op, alu_a, alu_b, disp_err} !== 36'h0)
      $display("FAIL rst_alu got start=%b op=%b a=%h b=%h err=%b exp all 0", alu_start, alu_op, alu_a, alu_b, disp_err);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    press(4'h1); press(4'h2); press(4'h3);
    total++; if (disp_value !== 16'h0123) $display("FAIL add_dispA got %h exp 0123", disp_value); else pass_cnt++;
    total++; if (digit_count !== 3'd3) $display("FAIL add_cntA got %0d exp 3", digit_count); else pass_cnt++;
    press(4'hA);
    total++; if (state_dbg !== 3'd1) $display("FAIL add_opstate got %0d exp 1", state_dbg); else pass_cnt++;
    total++; if (disp_value !== 16'h0123) $display("FAIL add_dispOp got %h exp 0123", disp_value); else pass_cnt++;
    press(4'h4); press(4'h5);
    total++; if (disp_value !== 16'h0045) $display("FAIL add_dispB got %h exp 0045", disp_value); else pass_cnt++;
    press(4'hE);
    total++; if (state_dbg !== 3'd3) $display("FAIL add_wait got %0d exp 3", state_dbg); else pass_cnt++;
    total++; if (start_cnt !== 1) $display("FAIL add_starts got %0d exp 1", start_cnt); else pass_cnt++;
    total++; if ({cap_op, cap_a, cap_b} !== {2'b00, 16'h0123, 16'h0045})
      $display("FAIL add_req got op=%b a=%h b=%h exp op=00 a=0123 b=0045", cap_op, cap_a, cap_b);
    else pass_cnt++;
    repeat (5) @(posedge clk); #1;
    total++; if (start_cnt !== 1) $display("FAIL add_nostart got %0d exp 1", start_cnt); else pass_cnt++;
    alu_reply(16'h0168, 1'b0);
    total++; if (state_dbg !== 3'd4) $display("FAIL add_show got %0d exp 4", state_dbg); else pass_cnt++;
    total++; if (disp_value !== 16'h0168) $display("FAIL add_result got %h exp 0168", disp_value); else pass_cnt++;
  endtask

  task automatic test_chain();
    press(4'hA);
    total++; if (state_dbg !== 3'd1) $display("FAIL chain_state got %0d exp 1", state_dbg); else pass_cnt++;
    total++; if (disp_value !== 16'h0168) $display("FAIL chain_disp got %h exp 0168", disp_value); else pass_cnt++;
    press(4'h2); press(4'hE);
    total++; if (start_cnt !== 2) $display("FAIL chain_starts got %0d exp 2", start_cnt); else pass_cnt++;
    total++; if ({cap_op, cap_a, cap_b} !== {2'b00, 16'h0168, 16'h0002})
      $display("FAIL chain_req got op=%b a=%h b=%h exp op=00 a=0168 b=0002", cap_op, cap_a, cap_b);
    else pass_cnt++;
    alu_reply(16'h0170, 1'b0);
    total++; if (disp_value !== 16'h0170) $display("FAIL chain_result got %h exp 0170", disp_value); else pass_cnt++;
    press(4'h7);
    total++; if ({state_dbg, digit_count, disp_value} !== {3'd0, 3'd1, 16'h0007})
      $display("FAIL show_digit got st=%0d cnt=%0d disp=%h exp st=0 cnt=1 disp=0007", state_dbg, digit_count, disp_value);
    else pass_cnt++;
  endtask

  task automatic test_digit_limit();
    press(4'hD);
    for (int i = 0; i < 5; i++) press(4'h9);
    total++; if (disp_value !== 16'h9999) $display("FAIL lim_disp got %h exp 9999", disp_value); else pass_cnt++;
    total++; if (digit_count !== 3'd4) $display("FAIL lim_cnt got %0d exp 4", digit_count); else pass_cnt++;
    total++; if (state_dbg !== 3'd0) $display("FAIL lim_state got %0d exp 0", state_dbg); else pass_cnt++;
  endtask

  task automatic test_hold();
    press(4'hD);
    @(posedge clk); #1;
    key_code = 4'h7; key_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (disp_value !== 16'h0007) $display("FAIL hold_disp got %h exp 0007", disp_value); else pass_cnt++;
    total++; if (digit_count !== 3'd1) $display("FAIL hold_cnt got %0d exp 1", digit_count); else pass_cnt++;
  endtask

  task automatic test_op_replace();
    press(4'hD);
    press(4'h5); press(4'hB); press(4'hC); press(4'h2); press(4'hE);
    total++; if ({cap_op, cap_a, cap_b} !== {2'b10, 16'h0005, 16'h0002})
      $display("FAIL oprep_req got op=%b a=%h b=%h exp op=10 a=0005 b=0002", cap_op, cap_a, cap_b);
    else pass_cnt++;
    alu_reply(16'h0010, 1'b0);
  endtask

  task automatic test_error();
    press(4'hD);
    press(4'h1); press(4'hB); press(4'h2); press(4'hE);
    alu_reply(16'h0099, 1'b1);
    total++; if ({state_dbg, disp_err, disp_value} !== {3'd5, 1'b1, 16'h0})
      $display("FAIL err_enter got st=%0d err=%b disp=%h exp st=5 err=1 disp=0000", state_dbg, disp_err, disp_value);
    else pass_cnt++;
    press(4'h3);
    total++; if ({state_dbg, disp_value} !== {3'd5, 16'h0})
      $display("FAIL err_digit got st=%0d disp=%h exp st=5 disp=0000", state_dbg, disp_value);
    else pass_cnt++;
    press(4'hD);
    total++; if ({state_dbg, disp_err, disp_value} !== {3'd0, 1'b0, 16'h0})
      $display("FAIL err_clear got st=%0d err=%b disp=%h exp st=0 err=0 disp=0000", state_dbg, disp_err, disp_value);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    press(4'h1); press(4'hA); press(4'h1); press(4'hE);
    total++; if (state_dbg !== 3'd3) $display("FAIL abort_wait got %0d exp 3", state_dbg); else pass_cnt++;
    press(4'hD);
    total++; if (state_dbg !== 3'd6) $display("FAIL abort_state got %0d exp 6", state_dbg); else pass_cnt++;
    press(4'hD);
    total++; if (state_dbg !== 3'd6) $display("FAIL abort_2nd got %0d exp 6", state_dbg); else pass_cnt++;
    alu_reply(16'h0002, 1'b0);
    total++; if ({state_dbg, digit_count, disp_value, alu_a, alu_b} !== {3'd0, 3'd0, 16'h0, 16'h0, 16'h0})
      $display("FAIL abort_done got st=%0d cnt=%0d disp=%h a=%h b=%h exp all 0", state_dbg, digit_count, disp_value, alu_a, alu_b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    press(4'h2); press(4'hA); press(4'h3); press(4'hE);
    pulse_reset();
    total++; if (state_dbg !== 3'd0) $display("FAIL rstwait_state got %0d exp 0", state_dbg); else pass_cnt++;
    alu_reply(16'h0005, 1'b0);
    total++; if ({state_dbg, disp_value} !== {3'd0, 16'h0})
      $display("FAIL rstwait_done got st=%0d disp=%h exp st=0 disp=0000", state_dbg, disp_value);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_digit_limit();
    test_hold();
    test_op_replace();
    test_error();
    test_abort();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
